// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// ---------------
// Instruction-fetch sequencer for a word-addressed instruction memory that
// reads combinationally. The block owns the program counter and drives the
// memory address. Fetched words go into a two-entry prefetch queue, and decode
// takes them from the queue over a valid/ready handshake.
//
// Optional build macro: FETCH_PERF_EN
//   When defined, the block adds the saturating performance counters
//   perf_fetch_cnt and perf_stall_cnt. When undefined, the counters and their
//   ports are absent.
//
// Queue organisation: entry 0 is always the head. The head registers drive
// instr_valid, instr and instr_pc directly, so decode sees values straight
// from flops. A pop shifts entry 1 into entry 0. A push writes the first free
// slot after any pop for the same cycle has been applied.

module imem_fetch_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 64,
    parameter int QDEPTH   = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    // DEPTH is a power of two, so a PC modulo DEPTH is a bit mask.
    localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_nxt;

    // Prefetch queue storage. Entry 0 is the head.
    logic [31:0]       q_data     [QDEPTH];
    logic [ADDR_W-1:0] q_pc       [QDEPTH];
    logic [QDEPTH-1:0] q_vld;
    logic [31:0]       q_data_nxt [QDEPTH];
    logic [ADDR_W-1:0] q_pc_nxt   [QDEPTH];
    logic [QDEPTH-1:0] q_vld_nxt;

    logic in_run;
    logic in_drain;
    logic q_full;
    logic pop;
    logic push;
    logic flush;

    assign in_run   = (state == ST_RUN);
    assign in_drain = (state == ST_DRAIN);
    assign q_full   = q_vld[QDEPTH-1];

    // A redirect discards everything that would otherwise happen to the queue
    // in the same cycle, including a pop that decode is attempting.
    assign flush = redirect_valid && (in_run || in_drain);
    assign pop   = q_vld[0] && instr_ready && !flush;

    // halt_req stops fetching immediately. The queue contents at that point
    // are the only entries that remain to be drained.
    assign push  = in_run && !redirect_valid && !halt_req && (!q_full || pop);

    // Next-state logic for the fetch FSM
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A redirect empties the queue, so the drain has nothing
                // left to wait for.
                if (redirect_valid || !q_vld[0]) state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                if (enable && !halt_req) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Program-counter update: a redirect loads the PC in every state;
    // otherwise the PC advances only on a push
    always_comb begin
        fetch_pc_nxt = fetch_pc;
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc & PC_MASK;
        end else if (push) begin
            fetch_pc_nxt = (fetch_pc + PC_ONE) & PC_MASK;
        end
    end

    // Queue next-value computation: apply the pop shift, then place the push
    // in the first free slot, then let a flush override everything
    always_comb begin
        // NOTE: always_comb uses blocking '=' so that later statements see the
        // values written by earlier ones (the push lands after the pop shift);
        // the flops below use '<=' only.
        q_data_nxt = q_data;
        q_pc_nxt   = q_pc;
        q_vld_nxt  = q_vld;

        if (pop) begin
            q_data_nxt[0] = q_data[1];
            q_pc_nxt[0]   = q_pc[1];
            q_vld_nxt[0]  = q_vld[1];
            q_vld_nxt[1]  = 1'b0;
        end

        if (push) begin
            if (!q_vld_nxt[0]) begin
                q_data_nxt[0] = imem_rdata;
                q_pc_nxt[0]   = fetch_pc;
                q_vld_nxt[0]  = 1'b1;
            end else begin
                q_data_nxt[1] = imem_rdata;
                q_pc_nxt[1]   = fetch_pc;
                q_vld_nxt[1]  = 1'b1;
            end
        end

        if (flush) begin
            q_vld_nxt = '0;
        end
    end

    // State and program-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= PC_RESET;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // Queue registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the queue payload is reset as well as the valid bits. The
        // entry-0 payload drives instr and instr_pc, which must read zero
        // during reset, and the queue is only two entries deep.
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
            q_vld <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= q_data_nxt[i];
                q_pc[i]   <= q_pc_nxt[i];
            end
            q_vld <= q_vld_nxt;
        end
    end

    // Decode-facing outputs come straight from the head-entry flops
    assign instr_valid = q_vld[0];
    assign instr       = q_data[0];
    assign instr_pc    = q_pc[0];
    assign imem_addr   = fetch_pc;
    assign halted      = (state == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic stall;

    // A stall is a RUN cycle in which a full queue blocks the fetch.
    assign stall = in_run && q_full && !pop;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl. The bench holds its own 64-word
// instruction memory model, which the DUT reads combinationally. Inputs
// change 1 ns after each rising edge. Outputs are sampled at that same point,
// so each sample shows the register state produced by the edge just taken.

module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        halt_req;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [64];

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[5:0]];

    // Standard program at 0, 1, 2 and 8. Every other word is a tagged filler.
    function automatic logic [31:0] prog_word(input int pc);
        case (pc)
            0:       return 32'h0000_7033;
            1:       return 32'h0010_0093;
            2:       return 32'h0020_0113;
            8:       return 32'h0020_8433;
            default: return 32'hC0DE_0000 | 32'(pc);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        enable         = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'd0;
        instr_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 8'd0; instr_ready = 1'b0;
        #3;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (instr_pc !== 8'd0) begin n_fail++; $display("FAIL reset_instr_pc: got %0d want 0", instr_pc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf_fetch: got %0d want 0", perf_fetch_cnt); end
        n_checks++; if (perf_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf_stall: got %0d want 0", perf_stall_cnt); end
`endif
        do_reset();
        step();
        // With enable low the block stays in IDLE and fetches nothing.
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", instr_valid); end
        n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL idle_addr: got %0d want 0", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        enable = 1'b1; instr_ready = 1'b1;
        step(); // IDLE -> RUN
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_entry_valid: got %b want 0", instr_valid); end
        step();
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid: got %b want 1", instr_valid); end
        n_checks++; if (instr !== 32'h0000_7033 || instr_pc !== 8'd0) begin n_fail++; $display("FAIL basic_pc0: got %h@%0d want 00007033@0", instr, instr_pc); end
        n_checks++; if (imem_addr !== 8'd1) begin n_fail++; $display("FAIL basic_addr1: got %0d want 1", imem_addr); end
        step();
        n_checks++; if (instr !== 32'h0010_0093 || instr_pc !== 8'd1 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pc1: got %h@%0d v%b want 00100093@1", instr, instr_pc, instr_valid); end
        step();
        n_checks++; if (instr !== 32'h0020_0113 || instr_pc !== 8'd2 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pc2: got %h@%0d v%b want 00200113@2", instr, instr_pc, instr_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        enable = 1'b1; instr_ready = 1'b0;
        step(); // RUN entry
        step(); // pc0 at the head
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_7033 || instr_pc !== 8'd0) begin n_fail++; $display("FAIL stall_head[%0d]: got %h@%0d v%b want 00007033@0", i, instr, instr_pc, instr_valid); end
            n_checks++; if (imem_addr !== 8'd2) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d want 2", i, imem_addr); end
        end
        instr_ready = 1'b1; // pc0 is accepted at the next edge
        step();
        n_checks++; if (instr !== 32'h0010_0093 || instr_pc !== 8'd1) begin n_fail++; $display("FAIL release_pc1: got %h@%0d want 00100093@1", instr, instr_pc); end
        step();
        n_checks++; if (instr !== 32'h0020_0113 || instr_pc !== 8'd2) begin n_fail++; $display("FAIL release_pc2: got %h@%0d want 00200113@2", instr, instr_pc); end
        step();
        n_checks++; if (instr_pc !== 8'd3 || instr !== prog_word(3)) begin n_fail++; $display("FAIL release_pc3: got %h@%0d want %h@3", instr, instr_pc, prog_word(3)); end
    endtask

    task automatic test_redirect();
        do_reset();
        enable = 1'b1; instr_ready = 1'b1;
        repeat (5) step(); // head pc3, fetch_pc 4
        instr_ready = 1'b0;
        step(); // pc4 queued behind pc3
        n_checks++; if (instr_pc !== 8'd3 || imem_addr !== 8'd5) begin n_fail++; $display("FAIL redir_setup: got head %0d addr %0d want 3 / 5", instr_pc, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 8'd8;
        step();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_valid: got %b want 0", instr_valid); end
        n_checks++; if (imem_addr !== 8'd8) begin n_fail++; $display("FAIL redir_addr: got %0d want 8", imem_addr); end
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h0020_8433 || instr_pc !== 8'd8) begin n_fail++; $display("FAIL redir_target: got %h@%0d v%b want 00208433@8", instr, instr_pc, instr_valid); end
        step();
        n_checks++; if (instr_pc !== 8'd9 || instr !== prog_word(9)) begin n_fail++; $display("FAIL redir_next: got %h@%0d want %h@9", instr, instr_pc, prog_word(9)); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 8'd63;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'd63) begin n_fail++; $display("FAIL wrap_redirect: got v%b addr %0d want v0 addr 63", instr_valid, imem_addr); end
        step();
        n_checks++; if (instr_pc !== 8'd63 || instr !== prog_word(63)) begin n_fail++; $display("FAIL wrap_pc63: got %h@%0d want %h@63", instr, instr_pc, prog_word(63)); end
        n_checks++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL wrap_addr0: got %0d want 0", imem_addr); end
        step();
        n_checks++; if (instr_pc !== 8'd0 || instr !== 32'h0000_7033) begin n_fail++; $display("FAIL wrap_pc0: got %h@%0d want 00007033@0", instr, instr_pc); end
        step();
        n_checks++; if (instr_pc !== 8'd1 || instr !== 32'h0010_0093) begin n_fail++; $display("FAIL wrap_pc1: got %h@%0d want 00100093@1", instr, instr_pc); end
        redirect_valid = 1'b1; redirect_pc = 8'd70; // 70 mod 64 = 6
        step();
        redirect_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'd6) begin n_fail++; $display("FAIL mask_redirect: got v%b addr %0d want v0 addr 6", instr_valid, imem_addr); end
        step();
        n_checks++; if (instr_pc !== 8'd6 || instr !== prog_word(6)) begin n_fail++; $display("FAIL mask_pc6: got %h@%0d want %h@6", instr, instr_pc, prog_word(6)); end
    endtask

    task automatic test_halt();
        instr_ready = 1'b0;
        step(); // pc7 joins pc6, fetch_pc 8
        n_checks++; if (instr_pc !== 8'd6 || imem_addr !== 8'd8) begin n_fail++; $display("FAIL halt_setup: got head %0d addr %0d want 6 / 8", instr_pc, imem_addr); end
        halt_req = 1'b1; enable = 1'b0; instr_ready = 1'b1;
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd7 || halted !== 1'b0) begin n_fail++; $display("FAIL drain_pc7: got v%b pc %0d h%b want v1 pc 7 h0", instr_valid, instr_pc, halted); end
        n_checks++; if (imem_addr !== 8'd8) begin n_fail++; $display("FAIL drain_addr: got %0d want 8", imem_addr); end
        step();
        n_checks++; if (instr_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got v%b h%b want v0 h0", instr_valid, halted); end
        step();
        n_checks++; if (halted !== 1'b1 || imem_addr !== 8'd8) begin n_fail++; $display("FAIL halted_set: got h%b addr %0d want h1 addr 8", halted, imem_addr); end
        step();
        n_checks++; if (halted !== 1'b1 || imem_addr !== 8'd8 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halted_hold: got h%b addr %0d v%b want h1 addr 8 v0", halted, imem_addr, instr_valid); end
        halt_req = 1'b0; enable = 1'b1;
        step();
        n_checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL resume_entry: got h%b v%b want h0 v0", halted, instr_valid); end
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd8 || instr !== 32'h0020_8433) begin n_fail++; $display("FAIL resume_pc8: got %h@%0d v%b want 00208433@8", instr, instr_pc, instr_valid); end
    endtask

    task automatic test_redirect_halt();
        enable = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 8'd2; halt_req = 1'b1;
        step(); // flush into an empty DRAIN
        redirect_valid = 1'b0; halt_req = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 8'd2) begin n_fail++; $display("FAIL rh_drain: got v%b h%b addr %0d want v0 h0 addr 2", instr_valid, halted, imem_addr); end
        step();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rh_halted: got %b want 1", halted); end
        redirect_valid = 1'b1; redirect_pc = 8'd5;
        step(); // redirect in HALTED loads the PC only
        redirect_valid = 1'b0;
        n_checks++; if (halted !== 1'b1 || imem_addr !== 8'd5 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halted_redirect: got h%b addr %0d v%b want h1 addr 5 v0", halted, imem_addr, instr_valid); end
        enable = 1'b1;
        step();
        step();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd5 || instr !== prog_word(5)) begin n_fail++; $display("FAIL halted_resume_pc5: got %h@%0d v%b want %h@5", instr, instr_pc, instr_valid, prog_word(5)); end
    endtask

    task automatic test_mid_reset();
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", instr_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got v%b h%b want v0 h0", instr_valid, halted); end
        n_checks++; if (imem_addr !== 8'd0 || instr !== 32'h0 || instr_pc !== 8'd0) begin n_fail++; $display("FAIL midrst_regs: got addr %0d instr %h pc %0d want 0", imem_addr, instr, instr_pc); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
        do_reset();
        step();
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'd0) begin n_fail++; $display("FAIL postrst_idle: got v%b addr %0d want v0 addr 0", instr_valid, imem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = prog_word(i);
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_redirect_halt();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 64x32 word-addressed instruction memory (InstMem: combinational read, 8-bit word address).
- Owns the program counter and drives the memory address.
- Buffers fetched words in a 2-entry prefetch queue and hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, plus a halt/drain sequence.

Parameters:
- ADDR_W, 8, instruction memory address width (word index).
- DEPTH, 64, number of valid instruction words; PC wraps modulo DEPTH (must be a power of 2).
- QDEPTH, 2, prefetch queue entries (fixed at 2 for this revision).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start fetching from IDLE.
- halt_req  input  1  stop fetching and drain the queue.
- redirect_valid  input  1  one-cycle pulse: flush and refetch.
- redirect_pc  input  ADDR_W  target word address for a redirect.
- imem_addr  output  ADDR_W  address to InstMem, equal to fetch_pc.
- imem_rdata  input  32  instruction returned combinationally by InstMem.
- instr_valid  output  1  queue head is valid.
- instr  output  32  queue head instruction.
- instr_pc  output  ADDR_W  word address of instr.
- instr_ready  input  1  decode accepts the head this cycle.
- halted  output  1  HALTED state indicator.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, fetch_pc=RESET_PC, queue empty.
  - instr_valid=0, instr=0, instr_pc=0, halted=0, imem_addr=RESET_PC.
- States: IDLE, RUN, DRAIN, HALTED.
  - IDLE: no fetch. enable=1 -> RUN next cycle.
  - RUN:
    - Push when the queue is not full, or is full and popping this cycle.
    - Push = capture {imem_rdata, fetch_pc} at the edge; fetch_pc <= (fetch_pc+1) mod DEPTH. DEPTH-1 wraps to 0.
    - halt_req=1 -> DRAIN.
  - DRAIN: no pushes; pops continue. Queue empty -> HALTED.
  - HALTED: halted=1, no fetch. enable=1 with halt_req=0 -> RUN, resuming at the current fetch_pc.
- Pop: instr_valid && instr_ready at the edge.
  - Push and pop in the same cycle: occupancy unchanged.
  - Ordering is strictly FIFO.
- Latency:
  - First instruction valid 1 cycle after the RUN entry edge.
  - Steady state sustains 1 instr/cycle with instr_ready held high.
- instr_valid/instr/instr_pc are registered queue-head outputs. instr and instr_pc must stay stable while instr_valid=1 && instr_ready=0.
- Redirect (redirect_valid=1 in RUN or DRAIN):
  - Highest priority: flush queue, discard any same-cycle push and pop.
  - fetch_pc <= redirect_pc mod DEPTH; upper bits are ignored.
  - instr_valid=0 on the next cycle; first target instruction valid 1 cycle later.
  - Redirect in DRAIN: flush, go straight to HALTED, load fetch_pc.
  - Redirect in IDLE/HALTED: loads fetch_pc only; no state change.
- Simultaneous redirect and halt_req in RUN: redirect applies (flush, load PC), then -> DRAIN (empty) -> HALTED next cycle.
- Mid-operation reset: immediate return to reset values; queue contents lost.
- Queue full, instr_ready=0: fetch_pc holds, imem_addr holds.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both cleared on reset.
  - perf_fetch_cnt increments on each push.
  - perf_stall_cnt increments on each cycle in RUN with the queue full and no pop.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, enable=1, instr_ready=1, with InstMem holding the standard program -> instr 32'h00007033 (pc 0), 32'h00100093 (pc 1), 32'h00200113 (pc 2) on consecutive cycles, valid first asserted 1 cycle after entering RUN.
- instr_ready=0 for 5 cycles after the first instruction -> queue holds pc0,pc1; fetch_pc=2 stable; instr stays 32'h00007033. Release ready -> pc 0,1,2 in order, none lost or duplicated.
- redirect_valid with redirect_pc=8 while the queue holds pc3,pc4 -> next cycle instr_valid=0; following cycle instr=32'h00208433, instr_pc=8; pc3/pc4 never delivered.
- redirect_pc=8'd63, then ready=1 -> instr_pc sequence 63, 0, 1 (wrap). redirect_pc=8'd70 -> fetch resumes at pc 6.
- halt_req in RUN with 2 entries queued, ready=1 -> both delivered, halted=1 two cycles later, imem_addr frozen. Re-enable -> fetch continues at the next PC.
- Assert rst_n=0 mid-stream with instr_valid=1 -> same-cycle instr_valid=0, halted=0, imem_addr=RESET_PC. With FETCH_PERF_EN, counters read 0.
